payload_streamer: RTL and testbench
===================================

Name: payload_streamer

Overview:
Parametrised successor of the fixed 256-bit order payload serializer. Accepts a flattened order message (MSG_W bits) on a one-cycle enable pulse and queues it in a DEPTH-entry FIFO. Emits each message as ceil(MSG_W/DATA_W) AXI-Stream beats with full tready backpressure, a per-message byte-swap mode, tkeep on the final partial beat, and drop accounting. Sits between the order-field assembly logic and the TCP/MAC transmit stream.

Parameters:
MSG_W, 768, message width in bits; multiple of 8, ≥ DATA_W
DATA_W, 256, stream beat width in bits; multiple of 8
DEPTH, 4, message FIFO entries; ≥ 2
BEATS (localparam), ceil(MSG_W/DATA_W), beats per message
CNT_W (localparam), max(1,$clog2(BEATS)), beat index width

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  synchronous, active-high
enable  in  1  one-cycle pulse; capture msg and swap_en
msg  in  MSG_W  flattened message; bit 0 = byte 0 LSB
swap_en  in  1  1 = reverse byte order within each beat of this message
tready  in  1  downstream ready
tvalid  out  1  beat valid
tlast  out  1  final beat of message
tdata  out  DATA_W  beat data
tkeep  out  DATA_W/8  valid-byte mask
cnt  out  CNT_W  index of current beat, 0..BEATS-1
fifo_level  out  $clog2(DEPTH+1)  queued messages (excl. one in flight)
drop_cnt  out  16  saturating count of dropped messages
busy  out  1  tvalid | (fifo_level != 0)

Behaviour:
- Reset (sampled high at posedge): FIFO emptied, FSM→IDLE; tvalid, tlast, tdata, tkeep, cnt, fifo_level, drop_cnt all 0. Reset mid-message abandons it; no tlast issued.
- Push: enable=1 and FIFO not full → {swap_en, msg} written. Fullness evaluated before any same-cycle pop: enable while full drops the message, drop_cnt += 1, saturating at 0xFFFF.
- FSM IDLE: FIFO non-empty → pop into shadow register, cnt=0, tvalid=1 next cycle, →SEND. Pop happens regardless of tready.
- FSM SEND: beat transfers when tvalid & tready. Non-final beat: cnt+1. Final beat (cnt==BEATS-1): FIFO non-empty → pop next message same edge, cnt=0, tvalid stays 1 (no bubble); else tvalid=0, →IDLE.
- tvalid & !tready: tdata, tkeep, tlast, cnt held stable; tvalid never drops without a transfer.
- Latency: enable at edge N with FSM IDLE and FIFO empty → first beat valid after edge N+1.
- Beat k raw = msg[k*DATA_W +: DATA_W]; bits at or above MSG_W zero-filled. tkeep raw: all ones except final beat, where the low (MSG_W − (BEATS−1)*DATA_W)/8 bits are 1.
- swap_en=1: byte j of tdata = raw byte (DATA_W/8−1−j); tkeep reversed identically. Applies to every beat of that message only.
- tlast = tvalid & (cnt==BEATS-1). BEATS=1: every beat has tlast.
- fifo_level: +1 per push, −1 per pop; unchanged when both occur the same cycle.

Test Plan:
- Defaults, tready=1, one enable, msg = bytes 0x00..0x5F → 3 consecutive beats, cnt 0,1,2; beat0 byte0=0x00, beat2 byte31=0x5F; tkeep=all ones; tlast on cnt=2 only; tvalid first high after edge N+1.
- Same message, tready=0 for 3 cycles while cnt=1 → tdata/cnt held; message completes in 6 cycles; no duplicated or skipped beat.
- Three enables on consecutive cycles, tready=1 → 9 contiguous tvalid beats, tlast at beats 3/6/9, fifo_level peaks at 2, returns to 0.
- tready=0, six consecutive enables, DEPTH=4 → five accepted (one in shadow, four queued), fifo_level=4, drop_cnt=1; releasing tready streams 15 beats in order.
- swap_en=1 with the 0x00..0x5F message → beat0 byte0=0x1F, byte31=0x00; MSG_W=720 build: final beat tkeep low 26 bits set (swap: high 26 bits), padding bytes 0.
- Reset asserted during beat 1 with two messages queued → next cycle tvalid=0, fifo_level=0, drop_cnt=0; a new enable afterwards produces a clean 3-beat message starting at cnt=0.

Source files
------------

// File: rtl/payload_streamer_if.sv
// rtl/payload_streamer_if.sv - beat stream bundle between the payload streamer and the transmit path
interface payload_streamer_if #(
    parameter int DATA_W = 256
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;

    modport master (output tvalid, tlast, tdata, tkeep, input tready);
    modport slave  (input tvalid, tlast, tdata, tkeep, output tready);
endinterface

// File: rtl/payload_streamer.sv
// rtl/payload_streamer.sv - queued order message to beat stream serializer with per-message byte swap
module payload_streamer #(
    parameter int MSG_W  = 768,
    parameter int DATA_W = 256,
    parameter int DEPTH  = 4,
    localparam int BEATS = (MSG_W + DATA_W - 1) / DATA_W,
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic [MSG_W-1:0]   msg_i,
    input  logic               swap_en_i,
    payload_streamer_if.master m_axis,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [LVL_W-1:0]   fifo_level_o,
    output logic [15:0]        drop_cnt_o,
    output logic               busy_o
);

    localparam int KEEP_W     = DATA_W / 8;
    localparam int PAD_W      = BEATS * DATA_W;
    localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAST_BYTES = (MSG_W - (BEATS - 1) * DATA_W) / 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic {IDLE, SEND} state_t;

    // Message queue
    logic [MSG_W-1:0] mem_msg_q [DEPTH];
    logic [DEPTH-1:0] mem_swap_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic [15:0]      drop_q, drop_d;

    // Message in flight and registered stream outputs
    state_t              state_q;
    logic [PAD_W-1:0]    shadow_q;
    logic                shadow_swap_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                tvalid_q;
    logic                tlast_q;
    logic [DATA_W-1:0]   tdata_q;
    logic [KEEP_W-1:0]   tkeep_q;

    logic               fifo_empty, fifo_full, push, pop, xfer, on_last;
    logic [CNT_W-1:0]   cnt_inc;
    logic [PAD_W-1:0]   head_pad;
    logic               head_swap;

    // Select beat k of a zero-padded message, optionally byte-reversed
    function automatic logic [DATA_W-1:0] beat_data(input logic [PAD_W-1:0] m,
                                                    input logic sw,
                                                    input logic [CNT_W-1:0] k);
        logic [DATA_W-1:0] raw;
        logic [DATA_W-1:0] res;
        raw = DATA_W'(m >> (int'(k) * DATA_W));
        for (int j = 0; j < KEEP_W; j++) begin
            res[j*8 +: 8] = sw ? raw[(KEEP_W-1-j)*8 +: 8] : raw[j*8 +: 8];
        end
        return res;
    endfunction

    // Byte mask: full except on the final beat, reversed along with the data
    function automatic logic [KEEP_W-1:0] beat_keep(input logic sw, input logic last);
        logic [KEEP_W-1:0] raw;
        logic [KEEP_W-1:0] res;
        for (int j = 0; j < KEEP_W; j++) begin
            raw[j] = !last || (j < LAST_BYTES);
        end
        for (int j = 0; j < KEEP_W; j++) begin
            res[j] = sw ? raw[KEEP_W-1-j] : raw[j];
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Fullness is judged before any same-cycle pop so a full queue always drops
    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LVL);
    assign push       = enable_i && !fifo_full;
    assign xfer       = tvalid_q && m_axis.tready;
    assign on_last    = (cnt_q == LAST_CNT);
    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign pop        = !fifo_empty && ((state_q == IDLE) || (state_q == SEND && xfer && on_last));
    assign head_pad   = PAD_W'(mem_msg_q[rd_ptr_q]);
    assign head_swap  = mem_swap_q[rd_ptr_q];

    // Next queue occupancy and saturating drop counter
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
        drop_d = drop_q;
        if (enable_i && fifo_full && drop_q != 16'hFFFF) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // Queue storage: accepted message and its swap flag land at the tail
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_msg_q[wr_ptr_q]  <= msg_i;
            mem_swap_q[wr_ptr_q] <= swap_en_i;
        end
    end

    // Queue pointers, occupancy and drop accounting
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            level_q <= level_d;
            drop_q  <= drop_d;
        end
    end

    // Beat sequencer: load the queue head, walk its beats, chain the next message without a bubble
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            shadow_swap_q <= 1'b0;
            cnt_q         <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tdata_q       <= '0;
            tkeep_q       <= '0;
        end else if (pop) begin
            state_q       <= SEND;
            shadow_q      <= head_pad;
            shadow_swap_q <= head_swap;
            cnt_q         <= '0;
            tvalid_q      <= 1'b1;
            tlast_q       <= (BEATS == 1);
            tdata_q       <= beat_data(head_pad, head_swap, '0);
            tkeep_q       <= beat_keep(head_swap, BEATS == 1);
        end else if (state_q == SEND && xfer) begin
            if (on_last) begin
                state_q  <= IDLE;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end else begin
                cnt_q   <= cnt_inc;
                tlast_q <= (cnt_inc == LAST_CNT);
                tdata_q <= beat_data(shadow_q, shadow_swap_q, cnt_inc);
                tkeep_q <= beat_keep(shadow_swap_q, cnt_inc == LAST_CNT);
            end
        end
    end

    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign cnt_o         = cnt_q;
    assign fifo_level_o  = level_q;
    assign drop_cnt_o    = drop_q;
    assign busy_o        = tvalid_q | (level_q != '0);

endmodule

// File: tb/tb_payload_streamer.sv
// tb/tb_payload_streamer.sv - vector table, corner sequences and random traffic against a message-level model
module tb_payload_streamer;

    localparam int MSG_W  = 768;
    localparam int DATA_W = 256;
    localparam int DEPTH  = 4;
    localparam int BEATS  = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable, swap_en;
    logic [767:0] msg;
    logic [1:0]   cnt0;
    logic [2:0]   lvl0;
    logic [15:0]  drop0;
    logic         busy0;

    logic         en1, sw1;
    logic [719:0] msg1;
    logic [1:0]   cnt1;
    logic [2:0]   lvl1;
    logic [15:0]  drop1;
    logic         busy1;

    payload_streamer_if #(.DATA_W(DATA_W)) bus0();
    payload_streamer_if #(.DATA_W(DATA_W)) bus1();

    payload_streamer #(.MSG_W(MSG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut0 (
        .clk_i(clk), .reset_i(reset), .enable_i(enable), .msg_i(msg), .swap_en_i(swap_en),
        .m_axis(bus0), .cnt_o(cnt0), .fifo_level_o(lvl0), .drop_cnt_o(drop0), .busy_o(busy0));

    payload_streamer #(.MSG_W(720), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut1 (
        .clk_i(clk), .reset_i(reset), .enable_i(en1), .msg_i(msg1), .swap_en_i(sw1),
        .m_axis(bus1), .cnt_o(cnt1), .fifo_level_o(lvl1), .drop_cnt_o(drop1), .busy_o(busy1));

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: beat k of a message is bytes 32k..32k+31, missing bytes are zero, swap mirrors the beat
    function automatic logic [255:0] exp_data(input logic [767:0] m, input bit sw, input int k, input int msg_w);
        logic [255:0] r;
        int src, idx;
        for (int j = 0; j < 32; j++) begin
            src = sw ? 31 - j : j;
            idx = k * 32 + src;
            r[j*8 +: 8] = (idx < msg_w / 8) ? m[idx*8 +: 8] : 8'h00;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_keep(input bit sw, input int k, input int msg_w);
        logic [31:0] r;
        int src;
        for (int j = 0; j < 32; j++) begin
            src = sw ? 31 - j : j;
            r[j] = (k * 32 + src) < (msg_w / 8);
        end
        return r;
    endfunction

    // Message-level model: a queue of accepted messages plus the one being sent
    typedef struct { logic [767:0] m; bit sw; } msg_t;
    msg_t mq[$];
    msg_t cur;
    bit   mv = 0;
    int   mcnt = 0;
    int   mdrop = 0;

    task automatic model_step(input bit en, input logic [767:0] m, input bit sw, input bit rdy, input bit rst);
        bit full, take;
        msg_t n;
        if (rst) begin
            mq.delete(); mv = 0; mcnt = 0; mdrop = 0;
            return;
        end
        full = (mq.size() == DEPTH);
        take = (mq.size() > 0) && (!mv || (rdy && mcnt == BEATS - 1));
        if (mv && rdy) begin
            if (mcnt < BEATS - 1) mcnt++;
            else mv = 0;
        end
        if (take) begin
            cur = mq.pop_front(); mcnt = 0; mv = 1;
        end
        if (en) begin
            n.m = m; n.sw = sw;
            if (!full) mq.push_back(n);
            else if (mdrop < 65535) mdrop++;
        end
    endtask

    task automatic model_compare();
        check("tvalid", bus0.tvalid, mv);
        check("tlast", bus0.tlast, mv && mcnt == BEATS - 1);
        if (mv) begin
            check("cnt", cnt0, mcnt);
            check("tdata", bus0.tdata, exp_data(cur.m, cur.sw, mcnt, MSG_W));
            check("tkeep", bus0.tkeep, exp_keep(cur.sw, mcnt, MSG_W));
        end
        check("fifo_level", lvl0, mq.size());
        check("drop_cnt", drop0, mdrop);
        check("busy", busy0, mv || mq.size() > 0);
    endtask

    task automatic cycle(input bit en, input logic [767:0] m, input bit sw, input bit rdy, input bit rst);
        reset = rst; enable = en; msg = m; swap_en = sw; bus0.tready = rdy;
        @(posedge clk);
        model_step(en, m, sw, rdy, rst);
        #1;
        model_compare();
    endtask

    function automatic logic [767:0] rand_msg();
        logic [767:0] r;
        for (int w = 0; w < 24; w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    typedef struct {
        bit en; bit sw; bit rdy;
        bit e_valid; int e_cnt; bit e_last;
        logic [7:0] e_b0; logic [7:0] e_b31; logic [31:0] e_keep; int e_level;
    } vec_t;
    vec_t tbl[13];

    logic [767:0] base;
    int nbeats, nlast, peak, lastmask, gap, started, ended, found;

    initial begin
        for (int i = 0; i < 96; i++) base[i*8 +: 8] = 8'(i);
        reset = 1; enable = 0; swap_en = 0; msg = '0; bus0.tready = 0;
        en1 = 0; sw1 = 0; msg1 = '0; bus1.tready = 1;

        tbl[0]  = '{1, 0, 1, 0, 0, 0, 8'h00, 8'h00, 32'h0, 1};
        tbl[1]  = '{0, 0, 1, 1, 0, 0, 8'h00, 8'h1F, 32'hFFFFFFFF, 0};
        tbl[2]  = '{0, 0, 1, 1, 1, 0, 8'h20, 8'h3F, 32'hFFFFFFFF, 0};
        tbl[3]  = '{0, 0, 0, 1, 1, 0, 8'h20, 8'h3F, 32'hFFFFFFFF, 0};
        tbl[4]  = '{0, 0, 0, 1, 1, 0, 8'h20, 8'h3F, 32'hFFFFFFFF, 0};
        tbl[5]  = '{0, 0, 0, 1, 1, 0, 8'h20, 8'h3F, 32'hFFFFFFFF, 0};
        tbl[6]  = '{0, 0, 1, 1, 2, 1, 8'h40, 8'h5F, 32'hFFFFFFFF, 0};
        tbl[7]  = '{0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 32'h0, 0};
        tbl[8]  = '{1, 1, 1, 0, 0, 0, 8'h00, 8'h00, 32'h0, 1};
        tbl[9]  = '{0, 0, 1, 1, 0, 0, 8'h1F, 8'h00, 32'hFFFFFFFF, 0};
        tbl[10] = '{0, 0, 1, 1, 1, 0, 8'h3F, 8'h20, 32'hFFFFFFFF, 0};
        tbl[11] = '{0, 0, 1, 1, 2, 1, 8'h5F, 8'h40, 32'hFFFFFFFF, 0};
        tbl[12] = '{0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 32'h0, 0};

        // Reset state
        cycle(0, '0, 0, 0, 1);
        cycle(0, '0, 0, 0, 1);
        check("rst_tdata", bus0.tdata, 0);
        check("rst_tkeep", bus0.tkeep, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_dut1_tvalid", bus1.tvalid, 0);

        // Single message: latency, stall hold, then the swapped variant
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].en, base, tbl[i].sw, tbl[i].rdy, 0);
            check($sformatf("vec%0d_tvalid", i), bus0.tvalid, tbl[i].e_valid);
            check($sformatf("vec%0d_level", i), lvl0, tbl[i].e_level);
            if (tbl[i].e_valid) begin
                check($sformatf("vec%0d_cnt", i), cnt0, tbl[i].e_cnt);
                check($sformatf("vec%0d_tlast", i), bus0.tlast, tbl[i].e_last);
                check($sformatf("vec%0d_byte0", i), bus0.tdata[7:0], tbl[i].e_b0);
                check($sformatf("vec%0d_byte31", i), bus0.tdata[255:248], tbl[i].e_b31);
                check($sformatf("vec%0d_tkeep", i), bus0.tkeep, tbl[i].e_keep);
            end
        end

        // Three back-to-back enables stream as nine contiguous beats
        nbeats = 0; peak = 0; lastmask = 0; gap = 0; started = 0; ended = 0;
        for (int t = 0; t < 20; t++) begin
            cycle(t < 3, rand_msg(), 1'($urandom_range(0, 1)), 1, 0);
            if (int'(lvl0) > peak) peak = int'(lvl0);
            if (bus0.tvalid) begin
                if (ended != 0) gap = 1;
                started = 1;
                if (bus0.tlast) lastmask = lastmask | (1 << nbeats);
                nbeats++;
            end else if (started != 0) begin
                ended = 1;
            end
        end
        check("b2b_beats", nbeats, 9);
        check("b2b_tlast_pos", lastmask, 9'b100100100);
        check("b2b_peak_level", peak, 2);
        check("b2b_contiguous", gap, 0);
        check("b2b_final_level", lvl0, 0);

        // Overflow: six enables under backpressure, one dropped
        for (int t = 0; t < 6; t++) cycle(1, rand_msg(), 1'($urandom_range(0, 1)), 0, 0);
        check("ovf_level", lvl0, 4);
        check("ovf_drop", drop0, 1);
        nbeats = 0; nlast = 0;
        for (int t = 0; t < 40; t++) begin
            if (bus0.tvalid) begin
                nbeats++;
                if (bus0.tlast) nlast++;
            end
            cycle(0, '0, 0, 1, 0);
        end
        check("ovf_beats", nbeats, 15);
        check("ovf_tlasts", nlast, 5);
        check("ovf_idle", busy0, 0);

        // Reset mid-message with two queued
        cycle(1, rand_msg(), 0, 1, 0);
        cycle(1, rand_msg(), 0, 1, 0);
        cycle(1, rand_msg(), 0, 1, 0);
        check("mid_cnt", cnt0, 1);
        check("mid_level", lvl0, 2);
        cycle(0, '0, 0, 0, 1);
        check("mid_rst_tvalid", bus0.tvalid, 0);
        check("mid_rst_tlast", bus0.tlast, 0);
        check("mid_rst_level", lvl0, 0);
        check("mid_rst_drop", drop0, 0);
        cycle(1, base, 0, 1, 0);
        nbeats = 0; lastmask = 0;
        for (int t = 0; t < 6; t++) begin
            cycle(0, '0, 0, 1, 0);
            if (bus0.tvalid) begin
                if (int'(cnt0) != nbeats) lastmask = 1;
                nbeats++;
            end
        end
        check("post_rst_beats", nbeats, 3);
        check("post_rst_cnt_order", lastmask, 0);

        // 720-bit build: partial final beat, zero padding, swapped mask
        for (int s = 0; s < 2; s++) begin
            en1 = 1; sw1 = 1'(s); msg1 = base[719:0];
            cycle(0, '0, 0, 1, 0);
            en1 = 0;
            found = 0;
            for (int t = 0; t < 10 && found == 0; t++) begin
                if (bus1.tvalid && bus1.tlast) begin
                    found = 1;
                    check($sformatf("m720_s%0d_cnt", s), cnt1, 2);
                    check($sformatf("m720_s%0d_tkeep", s), bus1.tkeep, s ? 32'hFFFFFFC0 : 32'h03FFFFFF);
                    check($sformatf("m720_s%0d_tdata", s), bus1.tdata, exp_data(base, 1'(s), 2, 720));
                end else begin
                    cycle(0, '0, 0, 1, 0);
                end
            end
            check($sformatf("m720_s%0d_tlast_seen", s), found, 1);
        end
        cycle(0, '0, 0, 1, 0);
        check("m720_idle", bus1.tvalid, 0);

        // Random traffic with a backpressure window to force drops
        for (int t = 0; t < 1500; t++) begin
            bit rdy;
            if (t >= 400 && t < 600) rdy = ($urandom_range(0, 7) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            cycle($urandom_range(0, 2) == 0, rand_msg(), 1'($urandom_range(0, 1)), rdy,
                  $urandom_range(0, 399) == 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
